piece_move_ctrl: RTL
====================

PIECE_MOVE_CTRL -- requirements
Module: piece_move_ctrl

Interface
REQ-001 Parameter X_MAX, default 9, rightmost legal column index.
REQ-002 Parameter Y_MAX, default 19, bottom legal row index.
REQ-003 Port clk  in  1  single system clock, all state on rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port mode  in  `MODE_BITS  game mode (`MODE_PLAY, `MODE_DROP, other).
REQ-006 Port tick  in  1  one-cycle gravity pulse.
REQ-007 Ports btn_left_en, btn_right_en, btn_rotate_en, btn_down_en  in  1 each  one-cycle debounced button pulses.
REQ-008 Port spawn  in  1  one-cycle new-piece load pulse; spawn_x  in  `X_POS_IN_BITS  spawn column.
REQ-009 Port collide_valid  in  1  checker result strobe; collide  in  1  1 = test pose illegal.
REQ-010 Ports test_x / test_y / test_rot  out  `X_POS_IN_BITS / `Y_POS_IN_BITS / `BITS_ROT  candidate pose to checker.
REQ-011 Port test_valid  out  1  candidate pose presented, held until collide_valid.
REQ-012 Ports cur_x / cur_y / cur_rot  out  same widths  committed piece pose.
REQ-013 Port lock_pulse  out  1  one-cycle pulse, piece landed; busy  out  1  FSM not IDLE.

Function
REQ-014 Request pulses SHALL be latched into a 5-bit pending set (tick, left, right, rotate, down); repeated pulses of one type while pending SHALL merge.
REQ-015 States: IDLE, CHECK, COMMIT, LOCK, WAIT_SPAWN.
REQ-016 IDLE: if pending non-empty, select highest priority tick > left > right > rotate > down, clear that bit, form candidate, go CHECK next cycle.
REQ-017 In `MODE_DROP, IDLE SHALL issue a down candidate every time it is entered, ignoring left/right/rotate (cleared); pending tick/down also satisfied by it.
REQ-018 In modes other than PLAY/DROP, pending set SHALL be cleared and FSM SHALL stay IDLE.
REQ-019 Candidate: left x-1, right x+1, rotate rot+1 (mod 4, 3->0), tick/down y+1; other fields copy cur_*.
REQ-020 Left at x=0, right at x=X_MAX: rejected in IDLE without CHECK, zero cycles of test_valid, pose unchanged.
REQ-021 Tick/down at y=Y_MAX: go LOCK directly without CHECK.
REQ-022 CHECK: test_valid=1 and test_* stable until cycle collide_valid=1; latency unbounded.
REQ-023 collide=0 -> COMMIT (cur_* <= test_* next edge), then IDLE.
REQ-024 collide=1 on left/right/rotate -> IDLE, pose unchanged; on tick/down -> LOCK.
REQ-025 LOCK: lock_pulse=1 exactly one cycle, clear pending, go WAIT_SPAWN; requests ignored in WAIT_SPAWN.
REQ-026 spawn in any state SHALL load cur_x=spawn_x, cur_y=0, cur_rot=0, clear pending, drop test_valid, go IDLE; spawn beats same-cycle requests.
REQ-027 Request arriving same cycle a pending bit is cleared SHALL remain pending.
REQ-028 busy=1 in all states except IDLE.

Reset
REQ-029 rst_n low: state WAIT_SPAWN, pending 0, cur_* 0, test_* 0, test_valid 0, lock_pulse 0, busy 1; asserting mid-CHECK aborts check immediately.

Structure
REQ-030 State encodings, widths, mode codes SHALL live in shared tetris_def.vh; X_MAX/Y_MAX default from it.
REQ-031 One sub-module natural: move_req_arb (pending latch + priority select).

Verification
REQ-032 spawn spawn_x=4, btn_right_en, collide_valid=1 collide=0 after 3 cycles -> test_x=5 held 3 cycles, cur_x=5, busy back to 0.
REQ-033 cur_x=0, btn_left_en -> test_valid never asserts, cur_x stays 0.
REQ-034 cur_y=7, tick, collide=1 -> lock_pulse one cycle, state WAIT_SPAWN, later btn_left_en ignored.
REQ-035 btn_left_en and btn_rotate_en same cycle, cur_rot=3, both checks pass -> left committed first, then cur_rot=0.
REQ-036 mode=`MODE_DROP from cur_y=Y_MAX-2, no collisions -> two commits then lock_pulse at y=Y_MAX.
REQ-037 rst_n low during CHECK -> test_valid 0 same cycle asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/piece_move_ctrl_pkg.sv
// Shared types and constants for the falling-piece move controller.
// Pose widths, mode codes, FSM states and request bit positions.
package piece_move_ctrl_pkg;

  localparam int MODE_BITS     = 2;
  localparam int X_POS_IN_BITS = 4;
  localparam int Y_POS_IN_BITS = 5;
  localparam int BITS_ROT      = 2;

  localparam int X_MAX_DEF = 9;
  localparam int Y_MAX_DEF = 19;

  localparam logic [MODE_BITS-1:0] MODE_PLAY = 2'd1;
  localparam logic [MODE_BITS-1:0] MODE_DROP = 2'd2;

  // Request bit positions; lower index wins arbitration.
  localparam int RQ_TICK  = 0;
  localparam int RQ_LEFT  = 1;
  localparam int RQ_RIGHT = 2;
  localparam int RQ_ROT   = 3;
  localparam int RQ_DOWN  = 4;
  localparam int RQ_N     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_COMMIT,
    S_LOCK,
    S_WAIT_SPAWN
  } state_t;

  typedef struct packed {
    logic [X_POS_IN_BITS-1:0] x;
    logic [Y_POS_IN_BITS-1:0] y;
    logic [BITS_ROT-1:0]      rot;
  } pose_t;

endpackage

// File: rtl/move_req_arb.sv
// Pending move-request set with fixed-priority grant.
// Cleared bits see same-cycle new pulses re-set them.
module move_req_arb
  import piece_move_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RQ_N-1:0] i_req,
  input  logic [RQ_N-1:0] i_clr,
  input  logic            i_flush,
  output logic [RQ_N-1:0] o_grant
);

  logic [RQ_N-1:0] r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else if (i_flush) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~i_clr) | i_req;
    end
  end

  // Isolate the lowest set bit: highest priority pending request.
  assign o_grant = r_pend & (~r_pend + RQ_N'(1));

endmodule

// File: rtl/piece_move_ctrl.sv
// Move/rotate/gravity controller for the active piece.
// Proposes a candidate pose to the collision checker, commits or locks.
module piece_move_ctrl
  import piece_move_ctrl_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MODE_BITS-1:0]     mode,
  input  logic                     tick,
  input  logic                     btn_left_en,
  input  logic                     btn_right_en,
  input  logic                     btn_rotate_en,
  input  logic                     btn_down_en,
  input  logic                     spawn,
  input  logic [X_POS_IN_BITS-1:0] spawn_x,
  input  logic                     collide_valid,
  input  logic                     collide,
  output logic [X_POS_IN_BITS-1:0] test_x,
  output logic [Y_POS_IN_BITS-1:0] test_y,
  output logic [BITS_ROT-1:0]      test_rot,
  output logic                     test_valid,
  output logic [X_POS_IN_BITS-1:0] cur_x,
  output logic [Y_POS_IN_BITS-1:0] cur_y,
  output logic [BITS_ROT-1:0]      cur_rot,
  output logic                     lock_pulse,
  output logic                     busy
);

  state_t          r_state;
  state_t          w_next;
  pose_t           r_cur;
  pose_t           r_test;
  pose_t           w_cand;
  logic            r_tv;
  logic            w_tv_next;
  logic            r_vert;
  logic            w_vert;
  logic            w_load;
  logic            w_commit;
  logic            w_flush;
  logic [RQ_N-1:0] w_clr;
  logic [RQ_N-1:0] w_grant;
  logic [RQ_N-1:0] w_req;
  logic            w_at_bot;

  assign w_req = {btn_down_en, btn_rotate_en,
                  btn_right_en, btn_left_en, tick};

  move_req_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (w_req),
    .i_clr   (w_clr),
    .i_flush (w_flush),
    .o_grant (w_grant)
  );

  assign w_at_bot = (r_cur.y == Y_POS_IN_BITS'(Y_MAX));

  always_comb begin
    w_next    = r_state;
    w_cand    = r_cur;
    w_vert    = 1'b0;
    w_load    = 1'b0;
    w_commit  = 1'b0;
    w_flush   = 1'b0;
    w_clr     = '0;
    w_tv_next = r_tv;
    case (r_state)
      S_IDLE: begin
        if (mode == MODE_DROP) begin
          // Forced descent satisfies every pending request.
          w_clr    = '1;
          w_vert   = 1'b1;
          w_cand.y = r_cur.y + Y_POS_IN_BITS'(1);
          if (w_at_bot) w_next = S_LOCK;
          else          w_load = 1'b1;
        end else if (mode == MODE_PLAY) begin
          w_clr = w_grant;
          unique case (1'b1)
            w_grant[RQ_TICK], w_grant[RQ_DOWN]: begin
              w_vert   = 1'b1;
              w_cand.y = r_cur.y + Y_POS_IN_BITS'(1);
              if (w_at_bot) w_next = S_LOCK;
              else          w_load = 1'b1;
            end
            w_grant[RQ_LEFT]: begin
              w_cand.x = r_cur.x - X_POS_IN_BITS'(1);
              w_load   = (r_cur.x != '0);
            end
            w_grant[RQ_RIGHT]: begin
              w_cand.x = r_cur.x + X_POS_IN_BITS'(1);
              w_load   = (r_cur.x != X_POS_IN_BITS'(X_MAX));
            end
            w_grant[RQ_ROT]: begin
              w_cand.rot = r_cur.rot + BITS_ROT'(1);
              w_load     = 1'b1;
            end
            default: ;
          endcase
        end else begin
          w_flush = 1'b1;
        end
      end
      S_CHECK: begin
        if (collide_valid) begin
          w_tv_next = 1'b0;
          if (!collide)    w_next = S_COMMIT;
          else if (r_vert) w_next = S_LOCK;
          else             w_next = S_IDLE;
        end
      end
      S_COMMIT: begin
        w_commit = 1'b1;
        w_next   = S_IDLE;
      end
      S_LOCK: begin
        w_flush = 1'b1;
        w_next  = S_WAIT_SPAWN;
      end
      S_WAIT_SPAWN: w_flush = 1'b1;
      default:      w_next  = S_IDLE;
    endcase
    if (w_load) begin
      w_next    = S_CHECK;
      w_tv_next = 1'b1;
    end
    if (spawn) begin
      w_next    = S_IDLE;
      w_flush   = 1'b1;
      w_load    = 1'b0;
      w_commit  = 1'b0;
      w_tv_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_SPAWN;
      r_cur   <= '0;
      r_test  <= '0;
      r_tv    <= 1'b0;
      r_vert  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tv    <= w_tv_next;
      if (spawn) begin
        r_cur.x   <= spawn_x;
        r_cur.y   <= '0;
        r_cur.rot <= '0;
      end else if (w_commit) begin
        r_cur <= r_test;
      end
      if (w_load) begin
        r_test <= w_cand;
        r_vert <= w_vert;
      end
    end
  end

  assign test_x     = r_test.x;
  assign test_y     = r_test.y;
  assign test_rot   = r_test.rot;
  assign test_valid = r_tv;
  assign cur_x      = r_cur.x;
  assign cur_y      = r_cur.y;
  assign cur_rot    = r_cur.rot;
  assign lock_pulse = (r_state == S_LOCK);
  assign busy       = (r_state != S_IDLE);

endmodule
